// File: rtl/bist_sequencer.sv
// Scan-BIST sequencing controller: seeds the pattern LFSR, alternates shift and
// capture windows for N_PATTERNS patterns, unloads, then pulses FINISH.
module bist_sequencer #(
   parameter int SCAN_LEN   = 8,
   parameter int N_PATTERNS = 16,
   parameter int CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   output logic             SEED,
   output logic             SCAN_EN,
   output logic             RUNNING,
   output logic             FINISH,
   output logic             BIST_END,
   output logic [CNT_W-1:0] PAT_CNT
);

   localparam int SH_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
   localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SCAN_LEN - 1);
   localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(N_PATTERNS);

   typedef enum logic [2:0] {
      IDLE, LOAD_SEED, SHIFT, CAPTURE, UNLOAD, FIN, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [SH_W-1:0]  sh_q, sh_d;
   logic [CNT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] pat_inc;

   assign pat_inc = pat_q + CNT_W'(1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         sh_q    <= '0;
         pat_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         pat_q   <= pat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      pat_d    = pat_q;
      SEED     = 1'b0;
      SCAN_EN  = 1'b0;
      RUNNING  = 1'b0;
      FINISH   = 1'b0;
      BIST_END = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) state_d = LOAD_SEED;
         end
         LOAD_SEED: begin
            SEED    = 1'b1;
            RUNNING = 1'b1;
            sh_d    = '0;
            pat_d   = '0;
            state_d = SHIFT;
         end
         SHIFT, UNLOAD: begin
            SCAN_EN = 1'b1;
            RUNNING = 1'b1;
            if (sh_q == SH_LAST) begin
               sh_d    = '0;
               state_d = (state_q == SHIFT) ? CAPTURE : FIN;
            end else begin
               sh_d = sh_q + SH_W'(1);
            end
         end
         CAPTURE: begin
            RUNNING = 1'b1;
            pat_d   = pat_inc;
            state_d = (pat_inc == PAT_LAST) ? UNLOAD : SHIFT;
         end
         FIN: begin
            FINISH  = 1'b1;
            RUNNING = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            BIST_END = 1'b1;
            // Clear the count on the way out so IDLE shows all-zero outputs.
            if (!START) begin
               state_d = IDLE;
               pat_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign PAT_CNT = pat_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Randomized scoreboard bench for bist_sequencer: two instances (4x3 and 1x1)
// checked every cycle against a run-position model of the BIST sequence.
module tb_bist_sequencer;

   localparam int L0 = 4, N0 = 3, L1 = 1, N1 = 1;

   typedef struct packed {
      logic       seed;
      logic       scan_en;
      logic       running;
      logic       finish;
      logic       bist_end;
      logic [7:0] pat_cnt;
   } out_t;

   logic CLK = 1'b0, RST = 1'b0, START = 1'b0;
   logic seed0, scan0, run0, fin0, end0;
   logic seed1, scan1, run1, fin1, end1;
   logic [7:0] pat0, pat1;
   out_t act0, act1;

   bist_sequencer #(.SCAN_LEN(L0), .N_PATTERNS(N0), .CNT_W(8)) u0 (
      .CLK(CLK), .RST(RST), .START(START), .SEED(seed0), .SCAN_EN(scan0),
      .RUNNING(run0), .FINISH(fin0), .BIST_END(end0), .PAT_CNT(pat0));

   bist_sequencer #(.SCAN_LEN(L1), .N_PATTERNS(N1), .CNT_W(8)) u1 (
      .CLK(CLK), .RST(RST), .START(START), .SEED(seed1), .SCAN_EN(scan1),
      .RUNNING(run1), .FINISH(fin1), .BIST_END(end1), .PAT_CNT(pat1));

   assign act0 = {seed0, scan0, run0, fin0, end0, pat0};
   assign act1 = {seed1, scan1, run1, fin1, end1, pat1};

   always #5 CLK = ~CLK;

   int   n_cmp = 0, n_bad = 0;
   out_t q0[$], q1[$];
   int   mode[2];   // 0 idle, 1 running, 2 done
   int   tpos[2];   // cycle index within run, SEED cycle = 0

   task automatic chk(input string nm, input out_t act, input out_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got seed=%b scan=%b run=%b fin=%b end=%b pat=%0d, expected seed=%b scan=%b run=%b fin=%b end=%b pat=%0d",
                  nm, $time, act.seed, act.scan_en, act.running, act.finish, act.bist_end, act.pat_cnt,
                  exp.seed, exp.scan_en, exp.running, exp.finish, exp.bist_end, exp.pat_cnt);
      end
   endtask

   function automatic int run_last(input int l, input int n);
      return 1 + n * (l + 1) + l;
   endfunction

   // Run = seed, N x (L shift + 1 capture), L unload, finish.
   function automatic out_t ref_out(input int md, input int t, input int l, input int n);
      out_t o = '0;
      int u, p, r;
      if (md == 1) begin
         o.running = 1'b1;
         if (t == 0) o.seed = 1'b1;
         else if (t == run_last(l, n)) begin
            o.finish  = 1'b1;
            o.pat_cnt = 8'(n);
         end else begin
            u = t - 1;
            p = u / (l + 1);
            r = u % (l + 1);
            o.scan_en = (r < l);
            o.pat_cnt = 8'(p);
         end
      end else if (md == 2) begin
         o.bist_end = 1'b1;
         o.pat_cnt  = 8'(n);
      end
      return o;
   endfunction

   function automatic void step(input int k, input logic st, input logic rs);
      int l = (k == 0) ? L0 : L1;
      int n = (k == 0) ? N0 : N1;
      if (!rs) mode[k] = 0;
      else case (mode[k])
         0: if (st) begin mode[k] = 1; tpos[k] = 0; end
         1: if (tpos[k] == run_last(l, n)) mode[k] = 2; else tpos[k]++;
         default: if (!st) mode[k] = 0;
      endcase
   endfunction

   // Inputs change on the falling edge; expectation for the following cycle is queued.
   task automatic drive_rst(input logic st, input logic rs);
      @(negedge CLK);
      START = st;
      RST   = rs;
      step(0, st, rs);
      step(1, st, rs);
      q0.push_back(ref_out(mode[0], tpos[0], L0, N0));
      q1.push_back(ref_out(mode[1], tpos[1], L1, N1));
   endtask

   task automatic drive(input logic st);
      drive_rst(st, RST);
   endtask

   task automatic reset_mid();
      @(posedge CLK);
      #3;
      RST = 1'b0;
      #1;
      chk("async_rst_u0", act0, '0);
      chk("async_rst_u1", act1, '0);
      mode[0] = 0;
      mode[1] = 0;
   endtask

   // Monitor: pops and compares one expectation per cycle, plus a per-run
   // SCAN_EN-high tally on the 4x3 instance checked at FINISH.
   int scan_cnt = 0;
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (q0.size() > 0) chk("u0_cycle", act0, q0.pop_front());
         if (q1.size() > 0) chk("u1_cycle", act1, q1.pop_front());
         if (seed0) scan_cnt = 0;
         if (scan0) scan_cnt++;
         if (fin0) begin
            n_cmp++;
            if (scan_cnt != (N0 + 1) * L0) begin
               n_bad++;
               $display("FAIL scan_en_total: got %0d expected %0d", scan_cnt, (N0 + 1) * L0);
            end
         end
      end
   end

   initial begin
      mode[0] = 0; mode[1] = 0; tpos[0] = 0; tpos[1] = 0;
      // reset then idle
      repeat (3) drive_rst(1'b0, 1'b0);
      drive_rst(1'b0, 1'b1);
      repeat (10) drive(1'b0);
      // nominal run, hold START past BIST_END, drop, restart
      repeat (28) drive(1'b1);
      drive(1'b0);
      repeat (26) drive(1'b1);
      repeat (3) drive(1'b0);
      // START glitching during a run
      drive(1'b1);
      repeat (20) drive(1'($urandom_range(0, 1)));
      repeat (30) drive(1'b0);
      // mid-run reset during the second shift window of the 4x3 instance
      repeat (8) drive(1'b1);
      reset_mid();
      repeat (2) drive_rst(1'b1, 1'b0);
      drive_rst(1'b1, 1'b1);
      repeat (30) drive(1'b1);
      repeat (3) drive(1'b0);
      // random START levels with random hold lengths
      for (int i = 0; i < 25; i++) begin
         logic s;
         s = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 30)) drive(s);
      end
      repeat (3) drive(1'b0);
      @(posedge CLK);
      #2;
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: got %0d/%0d left expected 0/0", q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
